// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory controller: default
// geometry and the controller state encoding.
package imem_pkg;

    // Default instruction RAM geometry: 1024 words of 32 bits.
    localparam int IMEM_AW = 10;
    localparam int IMEM_DW = 32;

    // Controller states. CLEAR is the reset state so the RAM is always
    // zero-filled before the first fetch or load is served.
    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        RESP  = 2'd2
    } imem_state_t;

    // Bit positions of the two requesters inside the arbiter vectors.
    localparam int REQ_FETCH = 0;
    localparam int REQ_LOAD  = 1;

endpackage

// File: rtl/imem_ctrl_if.sv
// Bus bundle between the instruction-memory controller, its requesters
// and the synchronous RAM. The slave modport is the controller's view;
// the master modport is the view of the surrounding system.
interface imem_ctrl_if #(
    parameter int AW = imem_pkg::IMEM_AW,
    parameter int DW = imem_pkg::IMEM_DW
) ();
    import imem_pkg::*;

    // Zero-fill control and status
    logic          clear_start;
    logic          busy;
    logic          clear_done;

    // Fetch port (read)
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_ack;
    logic [DW-1:0] fetch_data;

    // Loader port (write)
    logic          load_req;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          load_ack;

    // RAM port
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  clear_start,
        output busy,
        output clear_done,
        input  fetch_req,
        input  fetch_addr,
        output fetch_ack,
        output fetch_data,
        input  load_req,
        input  load_addr,
        input  load_data,
        output load_ack,
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport master (
        output clear_start,
        input  busy,
        input  clear_done,
        output fetch_req,
        output fetch_addr,
        input  fetch_ack,
        input  fetch_data,
        output load_req,
        output load_addr,
        output load_data,
        input  load_ack,
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/imem_ctrl_rr_arb2.sv
// Two-way round-robin arbiter. When both requests are present the one
// that was not granted last wins; the pointer moves only on a real grant.
// After reset the pointer favours req[0] (the fetch port).
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_b,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] grant
);

    // ptr_q = 0 favours req[0], ptr_q = 1 favours req[1]
    logic ptr_q;
    logic ptr_d;

    // Grant selection and pointer advance
    always_comb begin
        grant = 2'b00;
        if (grant_en) begin
            unique case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
        ptr_d = ptr_q;
        if (grant[0]) begin
            ptr_d = 1'b1;
        end else if (grant[1]) begin
            ptr_d = 1'b0;
        end
    end

    // Pointer register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/imem_ctrl.sv
// Instruction-memory controller: zero-fills the RAM after reset or on
// request, then serves single-word fetches and loader writes, one access
// per two cycles (grant cycle in IDLE, acknowledge cycle in RESP).
module imem_ctrl #(
    parameter int AW = imem_pkg::IMEM_AW,
    parameter int DW = imem_pkg::IMEM_DW
) (
    input  logic        clk,
    input  logic        reset_b,
    imem_ctrl_if.slave  bus
);
    import imem_pkg::*;

    localparam logic [AW-1:0] CLR_LAST = '1;

    imem_state_t   state_q,      state_d;
    logic [AW-1:0] clr_cnt_q,    clr_cnt_d;
    logic          clr_pend_q,   clr_pend_d;    // clear_start seen during RESP
    logic          clr_done_q,   clr_done_d;
    logic          gnt_load_q,   gnt_load_d;    // access being acked is a load
    logic [DW-1:0] fetch_data_q, fetch_data_d;
    // High only while reset is applied; keeps the RAM port quiet even
    // though the state register already sits in CLEAR.
    logic          rst_hold_q,   rst_hold_d;

    logic          clear_req;
    logic          arb_en;
    logic [1:0]    arb_req;
    logic [1:0]    grant;

    // A pending clear always wins over fetch/load in IDLE.
    assign clear_req = bus.clear_start | clr_pend_q;
    assign arb_en    = (state_q == IDLE) && !clear_req;
    assign arb_req[REQ_FETCH] = bus.fetch_req;
    assign arb_req[REQ_LOAD]  = bus.load_req;

    rr_arb2 u_arb (
        .clk      (clk),
        .reset_b  (reset_b),
        .req      (arb_req),
        .grant_en (arb_en),
        .grant    (grant)
    );

    // Next-state computation for the controller FSM and its datapath
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        clr_pend_d   = clr_pend_q;
        clr_done_d   = 1'b0;
        gnt_load_d   = gnt_load_q;
        fetch_data_d = fetch_data_q;
        rst_hold_d   = 1'b0;

        unique case (state_q)
            CLEAR: begin
                // The first cycle after reset release writes address 0,
                // so the counter must not move on the release edge.
                if (!rst_hold_q) begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                    if (clr_cnt_q == CLR_LAST) begin
                        state_d    = IDLE;
                        clr_done_d = 1'b1;
                    end
                end
            end
            IDLE: begin
                if (clear_req) begin
                    state_d    = CLEAR;
                    clr_cnt_d  = '0;
                    clr_pend_d = 1'b0;
                end else if (grant != 2'b00) begin
                    state_d    = RESP;
                    gnt_load_d = grant[REQ_LOAD];
                end
            end
            RESP: begin
                state_d = IDLE;
                if (bus.clear_start) begin
                    clr_pend_d = 1'b1;
                end
                if (!gnt_load_q) begin
                    fetch_data_d = bus.mem_rdata;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_q      <= CLEAR;
            clr_cnt_q    <= '0;
            clr_pend_q   <= 1'b0;
            clr_done_q   <= 1'b0;
            gnt_load_q   <= 1'b0;
            fetch_data_q <= '0;
            rst_hold_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            clr_pend_q   <= clr_pend_d;
            clr_done_q   <= clr_done_d;
            gnt_load_q   <= gnt_load_d;
            fetch_data_q <= fetch_data_d;
            rst_hold_q   <= rst_hold_d;
        end
    end

    // Status, acknowledge and read-data outputs
    always_comb begin
        bus.busy       = (state_q == CLEAR);
        bus.clear_done = clr_done_q;
        bus.fetch_ack  = (state_q == RESP) && !gnt_load_q;
        bus.load_ack   = (state_q == RESP) &&  gnt_load_q;
        // Read data passes straight through in the ack cycle and is
        // held from the register at all other times.
        bus.fetch_data = fetch_data_d;
    end

    // RAM port drive: zero-fill writes in CLEAR, granted access in IDLE
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        unique case (state_q)
            CLEAR: begin
                bus.mem_en   = !rst_hold_q;
                bus.mem_we   = !rst_hold_q;
                bus.mem_addr = clr_cnt_q;
            end
            IDLE: begin
                bus.mem_en = (grant != 2'b00);
                if (grant[REQ_LOAD]) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_addr  = bus.load_addr;
                    bus.mem_wdata = bus.load_data;
                end else begin
                    bus.mem_addr  = bus.fetch_addr;
                end
            end
            default: begin
                bus.mem_en = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_ctrl.sv
// Scoreboard bench for imem_ctrl: drivers push the expected acknowledge
// for each access, a negedge monitor pops and compares whenever an ack
// appears, and also tracks every zero-fill sequence.
module tb_imem_ctrl;
    import imem_pkg::*;

    typedef struct packed {
        logic        is_fetch;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic reset_b;
    int   n_pass;
    int   n_total;
    exp_t sb[$];
    logic [31:0] ram [0:(1<<IMEM_AW)-1];
    logic [31:0] rdata_q;

    imem_ctrl_if #(.AW(IMEM_AW), .DW(IMEM_DW)) bus ();

    imem_ctrl #(.AW(IMEM_AW), .DW(IMEM_DW)) u_dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM model driven by the controller's RAM port
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            rdata_q <= ram[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = rdata_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor: acknowledges against the scoreboard, zero-fill order
    initial begin
        int   clr_wr;
        bit   clr_bad;
        exp_t e;
        clr_wr  = 0;
        clr_bad = 0;
        forever begin
            @(negedge clk);
            if (!reset_b) begin
                clr_wr  = 0;
                clr_bad = 0;
            end else begin
                if (bus.busy && bus.mem_en && bus.mem_we) begin
                    if (clr_wr >= 1024 || int'(bus.mem_addr) != clr_wr || bus.mem_wdata != 32'h0)
                        clr_bad = 1;
                    clr_wr++;
                end
                if (bus.clear_done) begin
                    chk("clear_writes", clr_bad ? 32'hFFFF_FFFF : 32'(clr_wr), 32'd1024);
                    clr_wr  = 0;
                    clr_bad = 0;
                end
                if (bus.fetch_ack || bus.load_ack) begin
                    if (bus.busy) chk("ack_while_busy", 32'd1, 32'd0);
                    if (sb.size() == 0) begin
                        chk("unexpected_ack", {30'd0, bus.fetch_ack, bus.load_ack}, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        $display("ack: fetch=%0b load=%0b data=0x%08h", bus.fetch_ack, bus.load_ack, bus.fetch_data);
                        chk("ack_kind", {30'd0, bus.fetch_ack, bus.load_ack}, e.is_fetch ? 32'd2 : 32'd1);
                        if (e.is_fetch) chk("fetch_data", bus.fetch_data, e.data);
                    end
                end
            end
        end
    end

    // Single fetch or load with a 1-cycle latency check
    task automatic access(input bit is_fetch, input logic [9:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp);
        int lat;
        sb.push_back({is_fetch, is_fetch ? exp : 32'h0});
        @(negedge clk);
        if (is_fetch) begin
            bus.fetch_req  = 1'b1;
            bus.fetch_addr = addr;
        end else begin
            bus.load_req  = 1'b1;
            bus.load_addr = addr;
            bus.load_data = wdata;
        end
        lat = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (is_fetch ? bus.fetch_ack : bus.load_ack) begin
                lat = i;
                break;
            end
        end
        chk(is_fetch ? "fetch_latency" : "load_latency", 32'(lat), 32'd1);
        bus.fetch_req = 1'b0;
        bus.load_req  = 1'b0;
    endtask

    // Follow a zero-fill until clear_done, optionally injecting a
    // clear_start pulse or a reset when a given address is written.
    task automatic run_clear(input int inj_addr, input bit inj_reset, output int cyc);
        bit done;
        int ia;
        ia   = inj_addr;
        cyc  = 0;
        done = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            bus.clear_start = 1'b0;
            if (bus.busy) cyc++;
            if (bus.clear_done) begin
                done = 1;
                break;
            end
            if (ia >= 0 && bus.busy && bus.mem_en && bus.mem_we && int'(bus.mem_addr) == ia) begin
                if (inj_reset) begin
                    reset_b = 1'b0;
                    repeat (2) @(negedge clk);
                    reset_b = 1'b1;
                    cyc = 0;
                end else begin
                    bus.clear_start = 1'b1;
                end
                ia = -1;
            end
        end
        chk("clear_done_seen", {31'd0, done}, 32'd1);
        chk("busy_at_clear_done", {31'd0, bus.busy}, 32'd0);
        $display("clear: busy cycles=%0d done=%0b", cyc, done);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        logic [13:0] seq;
        n_pass = 0;
        n_total = 0;
        reset_b = 1'b0;
        bus.clear_start = 1'b0;
        bus.fetch_req = 1'b0;
        bus.fetch_addr = '0;
        bus.load_req = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;

        // Outputs while reset is held
        repeat (3) @(negedge clk);
        chk("rst_busy",       {31'd0, bus.busy},       32'd1);
        chk("rst_mem_en",     {31'd0, bus.mem_en},     32'd0);
        chk("rst_mem_we",     {31'd0, bus.mem_we},     32'd0);
        chk("rst_fetch_ack",  {31'd0, bus.fetch_ack},  32'd0);
        chk("rst_load_ack",   {31'd0, bus.load_ack},   32'd0);
        chk("rst_clear_done", {31'd0, bus.clear_done}, 32'd0);
        chk("rst_fetch_data", bus.fetch_data,          32'd0);

        // Power-up zero-fill
        reset_b = 1'b1;
        run_clear(-1, 1'b0, cyc);
        chk("init_clear_cycles", 32'(cyc), 32'd1024);
        @(negedge clk);
        chk("clear_done_one_cycle", {31'd0, bus.clear_done}, 32'd0);

        // Basic load/fetch, boundary address, last grant left on load
        access(1'b0, 10'h005, 32'h8C02_0004, 32'h0);
        access(1'b1, 10'h005, 32'h0, 32'h8C02_0004);
        access(1'b1, 10'h006, 32'h0, 32'h0000_0000);
        access(1'b0, 10'h3FF, 32'hA5A5_5A5A, 32'h0);
        access(1'b1, 10'h3FF, 32'h0, 32'hA5A5_5A5A);
        @(negedge clk);
        chk("fetch_data_hold", bus.fetch_data, 32'hA5A5_5A5A);
        access(1'b0, 10'h007, 32'h0BAD_F00D, 32'h0);

        // Both requesters held: fetch, load, fetch, load, one every 2 cycles
        sb.push_back({1'b1, 32'h8C02_0004});
        sb.push_back({1'b0, 32'h0});
        sb.push_back({1'b1, 32'h8C02_0004});
        sb.push_back({1'b0, 32'h0});
        @(negedge clk);
        bus.fetch_req = 1'b1;
        bus.fetch_addr = 10'h005;
        bus.load_req = 1'b1;
        bus.load_addr = 10'h007;
        bus.load_data = 32'h1122_3344;
        seq = '0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            seq = {seq[11:0], bus.fetch_ack, bus.load_ack};
        end
        bus.fetch_req = 1'b0;
        bus.load_req = 1'b0;
        chk("rr_ack_sequence", {18'd0, seq}, {18'd0, 14'b10_00_01_00_10_00_01});
        access(1'b1, 10'h007, 32'h0, 32'h1122_3344);

        // clear_start in RESP with a fetch still pending
        access(1'b0, 10'h009, 32'hCAFE_0009, 32'h0);
        sb.push_back({1'b1, 32'hCAFE_0009});
        sb.push_back({1'b1, 32'h0000_0000});
        @(negedge clk);
        bus.fetch_req = 1'b1;
        bus.fetch_addr = 10'h009;
        @(negedge clk);
        chk("resp_fetch_ack", {31'd0, bus.fetch_ack}, 32'd1);
        bus.clear_start = 1'b1;
        run_clear(-1, 1'b0, cyc);
        chk("latched_clear_cycles", 32'(cyc), 32'd1024);
        @(negedge clk);
        chk("fetch_after_clear_ack", {31'd0, bus.fetch_ack}, 32'd1);
        chk("clear_done_pulse_end", {31'd0, bus.clear_done}, 32'd0);
        bus.fetch_req = 1'b0;

        // clear_start during CLEAR is ignored
        access(1'b0, 10'h00A, 32'h1357_9BDF, 32'h0);
        @(negedge clk);
        bus.clear_start = 1'b1;
        run_clear(10, 1'b0, cyc);
        chk("clear_restart_ignored", 32'(cyc), 32'd1024);
        access(1'b1, 10'h00A, 32'h0, 32'h0000_0000);

        // Reset in the middle of a clear restarts it from address 0
        access(1'b0, 10'h005, 32'h8C02_0004, 32'h0);
        @(negedge clk);
        bus.clear_start = 1'b1;
        run_clear(500, 1'b1, cyc);
        chk("reset_mid_clear_cycles", 32'(cyc), 32'd1024);
        access(1'b1, 10'h005, 32'h0, 32'h0000_0000);
        access(1'b1, 10'h3FF, 32'h0, 32'h0000_0000);

        @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imem_ctrl.md
IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 Parameter AW, default 10, word-address width of instruction RAM (1024 words).
REQ-002 Parameter DW, default 32, instruction word width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset_b  in  1  synchronous, active-low reset; sampled on rising clk edge only.
REQ-005 clear_start  in  1  request zero-fill of whole RAM.
REQ-006 busy  out  1  high while clearing.
REQ-007 clear_done  out  1  one-cycle pulse when a zero-fill completes.
REQ-008 fetch_req  in  1  fetch request; held high until fetch_ack.
REQ-009 fetch_addr  in  AW  fetch word address; stable while fetch_req high.
REQ-010 fetch_ack  out  1  one-cycle pulse; fetch_data valid in the same cycle.
REQ-011 fetch_data  out  DW  read data.
REQ-012 load_req  in  1  loader write request; held high until load_ack.
REQ-013 load_addr  in  AW  write word address.
REQ-014 load_data  in  DW  write data.
REQ-015 load_ack  out  1  one-cycle pulse; the write has completed.
REQ-016 mem_en, mem_we  out  1 each  RAM enable and write strobe.
REQ-017 mem_addr  out  AW; mem_wdata  out  DW  RAM address and write data.
REQ-018 mem_rdata  in  DW  synchronous-read RAM data, valid one cycle after mem_en with mem_we=0.

Function
REQ-019 FSM states: CLEAR, IDLE, RESP.
REQ-020 CLEAR: each cycle drive mem_en=1, mem_we=1, mem_wdata=0, mem_addr=clr_cnt; clr_cnt increments 0..2^AW-1.
REQ-021 CLEAR with clr_cnt=2^AW-1 -> IDLE next cycle, clear_done pulses in that first IDLE cycle; a full clear takes exactly 2^AW cycles.
REQ-022 busy=1 exactly while in CLEAR; no fetch_ack or load_ack is issued in CLEAR.
REQ-023 clear_start during CLEAR is ignored (no restart); clear_start during RESP is latched and honoured on the next IDLE cycle.
REQ-024 IDLE priority: pending clear (clear_start or latched) > arbitrated fetch/load; a clear entry resets clr_cnt to 0.
REQ-025 Fetch/load arbitration is 2-way round-robin: when both requests are high, grant the one not granted last; the pointer updates only on a grant; after reset the pointer favours fetch.
REQ-026 Grant cycle (IDLE): mem_en=1; load -> mem_we=1, mem_addr=load_addr, mem_wdata=load_data; fetch -> mem_we=0, mem_addr=fetch_addr; then -> RESP.
REQ-027 RESP (exactly one cycle): pulse the granted ack; fetch_data=mem_rdata registered through; mem_en=0; no new grant; -> IDLE.
REQ-028 Latency: request high in IDLE cycle N -> ack in cycle N+1; maximum throughput is one access per 2 cycles.
REQ-029 fetch_data holds its last value outside fetch_ack cycles.
REQ-030 mem_en=0 in IDLE when no grant and no clear is pending.
REQ-031 A request dropped before its ack is undefined usage; the block needs no specific behaviour.

Reset
REQ-032 reset_b=0: state<=CLEAR, clr_cnt<=0, RR pointer<=fetch, clear latch<=0.
REQ-033 Output values during reset: busy=1, mem_en=0, mem_we=0, fetch_ack=0, load_ack=0, clear_done=0, fetch_data=0.
REQ-034 Zero-fill starts on the first cycle after reset_b returns high; reset mid-clear restarts the clear at address 0.
REQ-035 Reset during RESP drops the pending ack.

Structure
REQ-036 Shared package imem_pkg holds IMEM_AW=10, IMEM_DW=32 and the state encoding (CLEAR/IDLE/RESP).
REQ-037 The round-robin arbiter is the sub-module rr_arb2 (req[1:0], grant_en -> grant[1:0], registered pointer).

Verification
REQ-038 Release reset -> busy=1 for 1024 cycles, writes 0 to addresses 0..1023 in order, clear_done pulses once, then busy=0.
REQ-039 After clear: load addr 0x005 data 0x8C020004 -> load_ack next cycle; fetch addr 0x005 -> fetch_ack with fetch_data=0x8C020004.
REQ-040 fetch_req and load_req both held high for 8 cycles -> acks alternate fetch, load, fetch, load (4 total, one every 2 cycles).
REQ-041 clear_start asserted in a RESP cycle with fetch_req pending -> clear starts in the next IDLE; fetch is acked only after clear_done.
REQ-042 reset_b=0 at clr_cnt=500 -> clear restarts at address 0 and takes a full 1024 cycles.
REQ-043 clear_start pulsed at clr_cnt=10 -> ignored; clear_done arrives 1024 cycles after the original start.
